// File: rtl/vga_fb_writer.sv
// Bus-to-framebuffer pixel writer with a 4-deep write FIFO.
// Optional rectangle-free linear fill engine enabled by VGA_FB_FILL_EN.
module vga_fb_writer (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] WriteAddrIn,
    input  logic [31:0] WriteDataIn,
    input  logic        WriteEnableIn,
    input  logic [3:0]  WriteStrb,
    output logic        SlaverWriteReady,
    output logic [18:0] FbAddr,
    output logic [23:0] FbData,
    output logic        FbWriteEnable,
    input  logic        FbWriteOk,
    output logic        Busy
);
    localparam logic [18:0] PIX_TOTAL = 19'd307200;

`ifdef VGA_FB_FILL_EN
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FILL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DRAIN} state_t;
`endif

    state_t state, state_next;

    logic [18:0] fifo_addr [4];
    logic [23:0] fifo_data [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count, count_next;
    logic        empty, full;
    logic        accept, push, pop, go;
    logic [18:0] pix_idx;
    logic        unused_bits;

    assign unused_bits = ^{WriteAddrIn[31:22], WriteAddrIn[1:0],
                           WriteDataIn[31:24], WriteStrb[3]};

    assign empty   = (count == 3'd0);
    assign full    = (count == 3'd4);
    assign accept  = WriteEnableIn && SlaverWriteReady;
    assign pix_idx = WriteAddrIn[20:2];
    assign push    = accept && !WriteAddrIn[21]
                  && (WriteStrb[2:0] == 3'b111)
                  && (pix_idx < PIX_TOTAL);
    assign pop     = (state == S_DRAIN) && !empty && FbWriteOk;
    assign count_next = count + {2'b00, push} - {2'b00, pop};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= pix_idx;
            fifo_data[wr_ptr] <= WriteDataIn[23:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count_next;
        end
    end

`ifdef VGA_FB_FILL_EN
    logic [23:0] fill_color;
    logic [18:0] fill_start, fill_count, fill_idx, fill_left;
    logic        reg_wr, fill_null, fill_begin, fill_ack;
    logic        fill_last, fill_done;

    assign reg_wr     = accept && WriteAddrIn[21];
    assign fill_null  = (fill_count == 19'd0) || (fill_start >= PIX_TOTAL);
    assign fill_begin = (state == S_IDLE) && empty && go && !fill_null;
    assign fill_ack   = (state == S_FILL) && FbWriteOk;
    assign fill_last  = (fill_left == 19'd1)
                     || (fill_idx + 19'd1 == PIX_TOTAL);
    // Empty or off-screen requests complete from IDLE without a write.
    assign fill_done  = ((state == S_IDLE) && empty && go && fill_null)
                     || (fill_ack && fill_last);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            fill_color <= 24'd0;
            fill_start <= 19'd0;
            fill_count <= 19'd0;
            fill_idx   <= 19'd0;
            fill_left  <= 19'd0;
            go         <= 1'b0;
        end else begin
            if (fill_begin) begin
                fill_idx  <= fill_start;
                fill_left <= fill_count;
            end
            if (fill_ack) begin
                fill_idx  <= fill_idx + 19'd1;
                fill_left <= fill_left - 19'd1;
            end
            if (fill_done) go <= 1'b0;
            if (reg_wr) begin
                unique case (WriteAddrIn[3:2])
                    2'd0: fill_color <= WriteDataIn[23:0];
                    2'd1: fill_start <= WriteDataIn[18:0];
                    2'd2: fill_count <= WriteDataIn[18:0];
                    2'd3: if (WriteDataIn[0]) go <= 1'b1;
                endcase
            end
        end
    end
`else
    assign go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clrn) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (!empty) state_next = S_DRAIN;
`ifdef VGA_FB_FILL_EN
                else if (fill_begin) state_next = S_FILL;
`endif
            end
            S_DRAIN: if (count_next == 3'd0) state_next = S_IDLE;
`ifdef VGA_FB_FILL_EN
            S_FILL: if (fill_ack && fill_last) state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        FbWriteEnable = 1'b0;
        FbAddr        = 19'd0;
        FbData        = 24'd0;
        unique case (state)
            S_DRAIN: begin
                if (!empty) begin
                    FbWriteEnable = 1'b1;
                    FbAddr        = fifo_addr[rd_ptr];
                    FbData        = fifo_data[rd_ptr];
                end
            end
`ifdef VGA_FB_FILL_EN
            S_FILL: begin
                FbWriteEnable = 1'b1;
                FbAddr        = fill_idx;
                FbData        = fill_color;
            end
`endif
            default: ;
        endcase
`ifdef VGA_FB_FILL_EN
        SlaverWriteReady = !full && (state != S_FILL);
`else
        SlaverWriteReady = !full;
`endif
        Busy = !empty || (state != S_IDLE) || go;
    end
endmodule
